fmap_scan_gen: RTL

Parametrised two-level raster scan generator for the CNN datapath. It produces (row, col) feature-map coordinates with runtime-programmable extents and stride, and an optional linear buffer address. It advances under a valid/ready handshake so the convolution engine can stall it, and reports completion with a done pulse. It sits between the layer controller (start/limits) and the line-buffer/window-fetch logic (coordinates).

---
 rtl/fmap_scan_gen.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/fmap_scan_gen.sv
// fmap_scan_gen: two-level raster scan generator for the CNN datapath.
//
// Walks (row, col) over a runtime-programmed feature-map extent with a
// common stride on both axes. Scan positions are presented under a
// valid/ready handshake, and a one-cycle done pulse follows the final
// accepted position.
//
// Optional feature: define FMAP_SCAN_ADDR_EN to add the linear buffer
// address output addr = row*(col_max+1)+col. This also adds its
// row_base/row_step registers and the multiplier. Without the macro those
// are absent and all other behaviour is identical.
//
// Handshake: out_valid is a pure function of registered state and never
// depends on out_ready. A position is consumed on a rising edge where
// out_valid & out_ready. While out_valid & !out_ready, col/row/addr/row_end/last
// hold stable.
//
// state_dbg exposes the FSM state (0 = IDLE, 1 = RUN) for checkers.

module fmap_scan_gen #(
  parameter int COL_W    = 8,
  parameter int ROW_W    = 8,
  parameter int STRIDE_W = 3
`ifdef FMAP_SCAN_ADDR_EN
  ,
  parameter int ADDR_W   = COL_W + ROW_W
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [COL_W-1:0]    col_max,
  input  logic [ROW_W-1:0]    row_max,
  input  logic [STRIDE_W-1:0] stride,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [COL_W-1:0]    col,
  output logic [ROW_W-1:0]    row,
  output logic                row_end,
  output logic                last,
  output logic                busy,
  output logic                done,
`ifdef FMAP_SCAN_ADDR_EN
  output logic [ADDR_W-1:0]   addr,
`endif
  output logic                state_dbg
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  // Scan parameters latched at start; inputs are not looked at again
  // until the next IDLE.
  logic [COL_W-1:0]    col_max_q;
  logic [ROW_W-1:0]    row_max_q;
  logic [STRIDE_W-1:0] stride_q;
  logic                done_q;

  // A programmed stride of zero means a stride of one.
  logic [STRIDE_W-1:0] stride_eff;

  // Next-coordinate sums carry one extra bit, so col_max/row_max of
  // all-ones cannot wrap the comparison.
  logic [COL_W:0] col_sum;
  logic [ROW_W:0] row_sum;
  logic           col_wrap;
  logic           row_wrap;
  logic           hs;
  logic           final_hs;

  // Stride normalisation and next-position arithmetic.
  always_comb begin
    stride_eff = (stride == '0) ? STRIDE_W'(1) : stride;
    col_sum    = {1'b0, col} + (COL_W+1)'(stride_q);
    row_sum    = {1'b0, row} + (ROW_W+1)'(stride_q);
    col_wrap   = (col_sum > {1'b0, col_max_q});
    row_wrap   = (row_sum > {1'b0, row_max_q});
    hs         = (state == S_RUN) && out_ready;
    final_hs   = hs && col_wrap && row_wrap;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic: start only matters in IDLE, and the final
  // handshake returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)    state_nxt = S_RUN;
      S_RUN:   if (final_hs) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs. All flags are gated by RUN, so IDLE shows zeros even when
  // the latched limits are zero.
  always_comb begin
    out_valid = (state == S_RUN);
    busy      = (state == S_RUN);
    row_end   = (state == S_RUN) && col_wrap;
    last      = (state == S_RUN) && col_wrap && row_wrap;
    done      = done_q;
    state_dbg = state;
  end

  // Coordinate counters, latched parameters and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      col_max_q <= '0;
      row_max_q <= '0;
      stride_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      // Pulse lands in the IDLE cycle that follows the final handshake.
      done_q <= final_hs;
      case (state)
        S_IDLE: begin
          if (start) begin
            col_max_q <= col_max;
            row_max_q <= row_max;
            stride_q  <= stride_eff;
            col       <= '0;
            row       <= '0;
          end
        end
        S_RUN: begin
          if (final_hs) begin
            // Leave the coordinates at zero while idle.
            col <= '0;
            row <= '0;
          end else if (hs) begin
            if (!col_wrap) begin
              col <= col_sum[COL_W-1:0];
            end else begin
              col <= '0;
              row <= row_sum[ROW_W-1:0];
            end
          end
        end
        default: begin
          col <= '0;
          row <= '0;
        end
      endcase
    end
  end

`ifdef FMAP_SCAN_ADDR_EN
  // row_step is the address distance between scanned rows. row_base
  // tracks the address of column 0 of the current row, so a row change
  // needs no multiply at scan rate.
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] row_step;
  logic [ADDR_W-1:0] row_step_init;
  logic [ADDR_W-1:0] row_base_nxt;

  // Start-time multiply and the next row base.
  always_comb begin
    row_step_init = ADDR_W'(stride_eff) *
                    ADDR_W'({1'b0, col_max} + (COL_W+1)'(1));
    row_base_nxt  = row_base + row_step;
  end

  // Linear address tracking, in lock step with the coordinate counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr     <= '0;
      row_base <= '0;
      row_step <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr     <= '0;
            row_base <= '0;
            row_step <= row_step_init;
          end
        end
        S_RUN: begin
          if (final_hs) begin
            addr     <= '0;
            row_base <= '0;
          end else if (hs) begin
            if (!col_wrap) begin
              addr <= addr + ADDR_W'(stride_q);
            end else begin
              row_base <= row_base_nxt;
              addr     <= row_base_nxt;
            end
          end
        end
        default: begin
          addr     <= '0;
          row_base <= '0;
        end
      endcase
    end
  end
`endif

endmodule
